// File: rtl/eth_outfifo_axi_writer.sv
// -----------------------------------------------------------------------------
// eth_outfifo_axi_writer
//
// AXI4 write initiator that pushes a frame, delivered as a 32-bit word stream,
// into the Ethernet OUTFIFO slave window. The frame is cut into INCR bursts of
// at most MAX_BURST beats, all aimed at BASE_ADDR because the window is a FIFO.
//
// Ports:
//   clk         sole clock
//   rst         asynchronous reset, active-low
//   start_i     frame command, sampled only in IDLE
//   len_i       frame length in 32-bit words, sampled with start_i
//   s_data_i    stream data word
//   s_valid_i   stream word valid (held stable by producer until s_ready_o)
//   s_ready_o   stream word accepted
//   busy_o      frame in progress (AW, W, B)
//   done_o      one-cycle pulse when the frame completes
//   err_o       sticky write-response error, cleared by the next start_i
//   axi_mosi_o  AXI4 master request towards eth_outfifo_mosi_i
//   axi_miso_i  AXI4 slave response from eth_outfifo_miso_o
// -----------------------------------------------------------------------------
package eth_axi_pkg;

    typedef struct packed {
        logic [3:0]  awid;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        awlock;
        logic [3:0]  awcache;
        logic [2:0]  awprot;
        logic [3:0]  awqos;
        logic [3:0]  awregion;
        logic [0:0]  awuser;
        logic        awvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic [0:0]  wuser;
        logic        wvalid;
        logic        bready;
        logic [3:0]  arid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        arlock;
        logic [3:0]  arcache;
        logic [2:0]  arprot;
        logic [3:0]  arqos;
        logic [3:0]  arregion;
        logic [0:0]  aruser;
        logic        arvalid;
        logic        rready;
    } s_axi_mosi_t;

    typedef struct packed {
        logic        awready;
        logic        wready;
        logic [3:0]  bid;
        logic [1:0]  bresp;
        logic [0:0]  buser;
        logic        bvalid;
        logic        arready;
        logic [3:0]  rid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
        logic [0:0]  ruser;
        logic        rvalid;
    } s_axi_miso_t;

endpackage

module eth_outfifo_axi_writer
    import eth_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          MAX_BURST = 16,
    parameter int          LEN_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [31:0]       s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output s_axi_mosi_t       axi_mosi_o,
    input  s_axi_miso_t       axi_miso_i
);

    // Beat counters need LEN_W+1 bits for the min() and at least 9 bits to
    // hold a full 256-beat burst.
    localparam int CW = (LEN_W + 1 > 9) ? LEN_W + 1 : 9;
    localparam logic [CW-1:0] MAX_B = CW'(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_DONE
    } state_t;

    state_t            state;
    logic [LEN_W-1:0]  rem;
    logic [CW-1:0]     beats;
    logic [CW-1:0]     cnt;
    logic              aw_valid_q;
    logic [7:0]        aw_len_q;
    logic              done_q;
    logic              err_q;

    logic              in_w;
    logic              w_beat;
    logic              last_beat;

    function automatic logic [CW-1:0] burst_beats(input logic [LEN_W-1:0] r);
        logic [CW-1:0] r_w;
        r_w = CW'(r);
        return (r_w > MAX_B) ? MAX_B : r_w;
    endfunction

    function automatic logic [7:0] aw_len_of(input logic [CW-1:0] b);
        return 8'(b - CW'(1));
    endfunction

    assign in_w      = (state == S_W);
    assign last_beat = (cnt == beats - CW'(1));
    assign w_beat    = in_w & s_valid_i & axi_miso_i.wready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            rem        <= '0;
            beats      <= '0;
            cnt        <= '0;
            aw_valid_q <= 1'b0;
            aw_len_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        err_q <= 1'b0;
                        if (len_i != '0) begin
                            rem        <= len_i;
                            beats      <= burst_beats(len_i);
                            aw_len_q   <= aw_len_of(burst_beats(len_i));
                            aw_valid_q <= 1'b1;
                            state      <= S_AW;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                // aw_valid_q is always set here, so awready alone completes
                // the handshake, including when it was already high.
                S_AW: begin
                    if (axi_miso_i.awready) begin
                        aw_valid_q <= 1'b0;
                        cnt        <= '0;
                        state      <= S_W;
                    end
                end
                S_W: begin
                    if (w_beat) begin
                        cnt <= cnt + CW'(1);
                        rem <= rem - LEN_W'(1);
                        if (last_beat) begin
                            state <= S_B;
                        end
                    end
                end
                // An error response is recorded but the frame keeps going so
                // the producer's stream is always fully drained.
                S_B: begin
                    if (axi_miso_i.bvalid) begin
                        if (axi_miso_i.bresp != 2'b00) begin
                            err_q <= 1'b1;
                        end
                        if (rem != '0) begin
                            beats      <= burst_beats(rem);
                            aw_len_q   <= aw_len_of(burst_beats(rem));
                            aw_valid_q <= 1'b1;
                            state      <= S_AW;
                        end else begin
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end
                    end
                end
                // A zero-length frame enters with done_q clear and spends one
                // extra cycle here, so its pulse lands two cycles after start.
                S_DONE: begin
                    if (done_q) begin
                        done_q <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign s_ready_o = in_w & axi_miso_i.wready;
    assign busy_o    = (state == S_AW) || (state == S_W) || (state == S_B);
    assign done_o    = done_q;
    assign err_o     = err_q;

    // Fields are gated to zero outside their active phase so the whole bus
    // reads as zero in reset and idle; the read channels stay tied off.
    always_comb begin
        axi_mosi_o         = '0;
        axi_mosi_o.awvalid = aw_valid_q;
        axi_mosi_o.awaddr  = aw_valid_q ? BASE_ADDR : 32'h0;
        axi_mosi_o.awlen   = aw_valid_q ? aw_len_q : 8'h0;
        axi_mosi_o.awsize  = aw_valid_q ? 3'd2 : 3'd0;
        axi_mosi_o.awburst = aw_valid_q ? 2'b01 : 2'b00;
        axi_mosi_o.wvalid  = in_w & s_valid_i;
        axi_mosi_o.wdata   = in_w ? s_data_i : 32'h0;
        axi_mosi_o.wstrb   = in_w ? 4'hF : 4'h0;
        axi_mosi_o.wlast   = in_w & last_beat;
        axi_mosi_o.bready  = (state == S_B);
    end

    logic unused_miso;
    assign unused_miso = ^{axi_miso_i.bid, axi_miso_i.buser, axi_miso_i.arready,
                           axi_miso_i.rid, axi_miso_i.rdata, axi_miso_i.rresp,
                           axi_miso_i.rlast, axi_miso_i.ruser, axi_miso_i.rvalid};

endmodule

// File: tb/tb_eth_outfifo_axi_writer.sv
// -----------------------------------------------------------------------------
// Testbench for eth_outfifo_axi_writer: a scripted AXI slave and stream
// producer, a monitor recording handshakes, and directed scenario tasks.
// Inputs change #1 after posedge; the monitor samples on negedge.
// -----------------------------------------------------------------------------
module tb_eth_outfifo_axi_writer;
    import eth_axi_pkg::*;

    localparam logic [31:0] BASE = 32'hA000_0040;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [15:0] len_i;
    logic [31:0] s_data_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    s_axi_mosi_t axi_mosi_o;
    s_axi_miso_t axi_miso_i;

    eth_outfifo_axi_writer #(
        .BASE_ADDR (BASE),
        .MAX_BURST (16),
        .LEN_W     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .len_i      (len_i),
        .s_data_i   (s_data_i),
        .s_valid_i  (s_valid_i),
        .s_ready_o  (s_ready_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .axi_mosi_o (axi_mosi_o),
        .axi_miso_i (axi_miso_i)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // slave / producer configuration and state
    int         aw_delay;
    bit         w_toggle;
    bit         gap_mode;
    bit         prod_en;
    logic [1:0] bresp_tab [8];
    int         aw_cnt;
    bit         b_pending;
    int         b_idx;
    logic [31:0] prod_word;
    int         gap_ph;

    // monitor state
    bit          aw_hs_f, w_hs_f, wlast_hs_f, b_hs_f, s_hs_f, b_prev;
    int          n_aw, n_w, n_b, n_done, n_wlast, n_aw_wait;
    logic [7:0]  aw_len_q [$];
    logic [31:0] wdata_q [$];
    int          wlast_idx [$];
    logic        err_after [$];
    int          done_cyc, b_cyc, first_aw_cyc;
    bit          saw_busy, saw_awvalid, aw_wait_prev;
    logic [31:0] aw_addr_prev;
    logic [7:0]  aw_len_prev;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic clear_mon();
        aw_hs_f = 0; w_hs_f = 0; wlast_hs_f = 0; b_hs_f = 0; s_hs_f = 0; b_prev = 0;
        n_aw = 0; n_w = 0; n_b = 0; n_done = 0; n_wlast = 0; n_aw_wait = 0;
        aw_len_q.delete(); wdata_q.delete(); wlast_idx.delete(); err_after.delete();
        done_cyc = -1; b_cyc = -100; first_aw_cyc = -1;
        saw_busy = 0; saw_awvalid = 0; aw_wait_prev = 0;
    endtask

    // Monitor: records what will be accepted at the next posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (b_prev) begin
                err_after.push_back(err_o);
                b_prev = 0;
            end
            aw_hs_f    = axi_mosi_o.awvalid & axi_miso_i.awready;
            w_hs_f     = axi_mosi_o.wvalid & axi_miso_i.wready;
            wlast_hs_f = w_hs_f & axi_mosi_o.wlast;
            b_hs_f     = axi_mosi_o.bready & axi_miso_i.bvalid;
            s_hs_f     = s_valid_i & s_ready_o;
            if (busy_o) saw_busy = 1;
            if (axi_mosi_o.awvalid) begin
                saw_awvalid = 1;
                if (first_aw_cyc < 0) first_aw_cyc = cyc;
            end
            if (aw_wait_prev && axi_mosi_o.awvalid) begin
                total++;
                if (axi_mosi_o.awaddr !== aw_addr_prev || axi_mosi_o.awlen !== aw_len_prev) begin
                    bad++;
                    $display("FAIL aw_stable: got addr=%h len=%0d want addr=%h len=%0d",
                             axi_mosi_o.awaddr, axi_mosi_o.awlen, aw_addr_prev, aw_len_prev);
                end
            end
            aw_wait_prev = axi_mosi_o.awvalid & ~axi_miso_i.awready;
            if (aw_wait_prev) n_aw_wait++;
            aw_addr_prev = axi_mosi_o.awaddr;
            aw_len_prev  = axi_mosi_o.awlen;
            if (w_hs_f) begin
                total++;
                if (n_aw <= n_wlast || axi_mosi_o.wstrb !== 4'hF) begin
                    bad++;
                    $display("FAIL w_beat: got aw=%0d bursts_closed=%0d wstrb=%h want aw>closed wstrb=f",
                             n_aw, n_wlast, axi_mosi_o.wstrb);
                end
                wdata_q.push_back(axi_mosi_o.wdata);
                n_w++;
                if (axi_mosi_o.wlast) begin
                    wlast_idx.push_back(n_w - 1);
                    n_wlast++;
                end
            end
            if (aw_hs_f) begin
                total++;
                if (axi_mosi_o.awaddr !== BASE || axi_mosi_o.awsize !== 3'd2 ||
                    axi_mosi_o.awburst !== 2'b01 || axi_mosi_o.awid !== 4'd0) begin
                    bad++;
                    $display("FAIL aw_fields: got addr=%h size=%0d burst=%0d id=%0d want addr=%h size=2 burst=1 id=0",
                             axi_mosi_o.awaddr, axi_mosi_o.awsize, axi_mosi_o.awburst,
                             axi_mosi_o.awid, BASE);
                end
                aw_len_q.push_back(axi_mosi_o.awlen);
                n_aw++;
            end
            if (b_hs_f) begin
                n_b++;
                b_cyc  = cyc;
                b_prev = 1;
            end
            if (done_o) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    // Stream producer: holds each word until accepted, optionally gapped.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!prod_en) begin
                s_valid_i = 1'b0;
            end else begin
                if (s_hs_f) prod_word++;
                if (!(s_valid_i && !s_hs_f)) begin
                    gap_ph++;
                    s_valid_i = gap_mode ? (gap_ph % 3 != 0) : 1'b1;
                end
            end
            s_data_i = prod_word;
        end
    end

    // AXI slave model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                axi_miso_i = '0;
                aw_cnt     = 0;
                b_pending  = 0;
            end else begin
                if (aw_delay == 0) begin
                    axi_miso_i.awready = 1'b1;
                end else if (axi_mosi_o.awvalid) begin
                    aw_cnt++;
                    axi_miso_i.awready = (aw_cnt > aw_delay);
                end else begin
                    aw_cnt = 0;
                    axi_miso_i.awready = 1'b0;
                end
                axi_miso_i.wready = w_toggle ? ~axi_miso_i.wready : 1'b1;
                if (b_hs_f) begin
                    axi_miso_i.bvalid = 1'b0;
                    b_idx++;
                end
                if (wlast_hs_f) b_pending = 1;
                if (b_pending && !axi_miso_i.bvalid) begin
                    axi_miso_i.bvalid = 1'b1;
                    axi_miso_i.bresp  = (b_idx < 8) ? bresp_tab[b_idx] : 2'b00;
                    b_pending = 0;
                end
                if (!axi_miso_i.bvalid) axi_miso_i.bresp = 2'b00;
            end
        end
    end

    task automatic reset_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        start_i = 1'b0;
        len_i = '0;
        prod_en = 0;
        aw_delay = 0;
        w_toggle = 0;
        gap_mode = 0;
        foreach (bresp_tab[i]) bresp_tab[i] = 2'b00;
        b_idx = 0;
        b_pending = 0;
        gap_ph = 0;
        repeat (2) @(posedge clk);
        clear_mon();
        prod_word = 0;
        #1;
        rst = 1'b1;
    endtask

    task automatic start_frame(input int len, output int scyc);
        @(posedge clk);
        #1;
        start_i = 1'b1;
        len_i   = 16'(len);
        @(negedge clk);
        scyc = cyc;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (n_done != 0) break;
            @(posedge clk);
        end
        repeat (6) @(posedge clk);
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        total++;
        if (axi_mosi_o !== '0) begin
            bad++; $display("FAIL reset_mosi: got %h want 0", axi_mosi_o);
        end
        total++;
        if ({s_ready_o, busy_o, done_o, err_o} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0000", {s_ready_o, busy_o, done_o, err_o});
        end
        reset_all();
        repeat (3) @(posedge clk);
        total++;
        if (busy_o !== 1'b0 || axi_mosi_o.awvalid !== 1'b0) begin
            bad++; $display("FAIL idle_after_reset: got busy=%b awvalid=%b want 0 0",
                            busy_o, axi_mosi_o.awvalid);
        end
    endtask

    task automatic test_single();
        int scyc;
        reset_all();
        prod_en = 1;
        start_frame(5, scyc);
        wait_done(200);
        total++;
        if (aw_len_q.size() != 1 || aw_len_q[0] !== 8'd4) begin
            bad++; $display("FAIL single_aw: got n=%0d want n=1 awlen=4", aw_len_q.size());
        end
        total++;
        if (first_aw_cyc != scyc + 1) begin
            bad++; $display("FAIL single_aw_latency: got %0d want %0d", first_aw_cyc, scyc + 1);
        end
        total++;
        if (n_w != 5) begin
            bad++; $display("FAIL single_beats: got %0d want 5", n_w);
        end
        for (int i = 0; i < n_w; i++) begin
            total++;
            if (wdata_q[i] !== 32'(i)) begin
                bad++; $display("FAIL single_data[%0d]: got %0d want %0d", i, wdata_q[i], i);
            end
        end
        total++;
        if (n_wlast != 1 || wlast_idx[0] != 4) begin
            bad++; $display("FAIL single_wlast: got n=%0d want one wlast at beat 5", n_wlast);
        end
        total++;
        if (n_done != 1 || done_cyc != b_cyc + 1) begin
            bad++; $display("FAIL single_done: got n=%0d at %0d want 1 at %0d", n_done, done_cyc, b_cyc + 1);
        end
        total++;
        if (err_o !== 1'b0) begin
            bad++; $display("FAIL single_err: got %b want 0", err_o);
        end
    endtask

    task automatic test_multi();
        int scyc;
        int exp_len [3] = '{15, 15, 7};
        int exp_last [3] = '{15, 31, 39};
        reset_all();
        prod_en = 1;
        start_frame(40, scyc);
        wait_done(400);
        total++;
        if (n_aw != 3) begin
            bad++; $display("FAIL multi_naw: got %0d want 3", n_aw);
        end
        for (int i = 0; i < 3 && i < n_aw; i++) begin
            total++;
            if (aw_len_q[i] !== 8'(exp_len[i])) begin
                bad++; $display("FAIL multi_awlen[%0d]: got %0d want %0d", i, aw_len_q[i], exp_len[i]);
            end
        end
        total++;
        if (n_w != 40) begin
            bad++; $display("FAIL multi_beats: got %0d want 40", n_w);
        end
        for (int i = 0; i < n_w; i++) begin
            total++;
            if (wdata_q[i] !== 32'(i)) begin
                bad++; $display("FAIL multi_data[%0d]: got %0d want %0d", i, wdata_q[i], i);
            end
        end
        total++;
        if (n_wlast != 3 || wlast_idx[0] != exp_last[0] || wlast_idx[1] != exp_last[1] ||
            wlast_idx[2] != exp_last[2]) begin
            bad++; $display("FAIL multi_wlast: got n=%0d want 3 at 15,31,39", n_wlast);
        end
        total++;
        if (n_done != 1) begin
            bad++; $display("FAIL multi_done: got %0d want 1", n_done);
        end
    endtask

    task automatic test_exact();
        int scyc;
        reset_all();
        prod_en = 1;
        start_frame(32, scyc);
        wait_done(400);
        total++;
        if (n_aw != 2 || aw_len_q[0] !== 8'd15 || aw_len_q[1] !== 8'd15) begin
            bad++; $display("FAIL exact_aw: got n=%0d want 2 bursts of awlen 15", n_aw);
        end
        total++;
        if (n_w != 32 || n_done != 1) begin
            bad++; $display("FAIL exact_beats: got beats=%0d done=%0d want 32 1", n_w, n_done);
        end
    endtask

    task automatic test_zero();
        int scyc;
        reset_all();
        prod_en = 1;
        start_frame(0, scyc);
        wait_done(50);
        total++;
        if (n_done != 1 || done_cyc != scyc + 2) begin
            bad++; $display("FAIL zero_done: got n=%0d at %0d want 1 at %0d", n_done, done_cyc, scyc + 2);
        end
        total++;
        if (saw_awvalid || saw_busy || n_w != 0) begin
            bad++; $display("FAIL zero_quiet: got awvalid=%0d busy=%0d beats=%0d want 0 0 0",
                            saw_awvalid, saw_busy, n_w);
        end
    endtask

    task automatic test_backpressure();
        int scyc;
        reset_all();
        aw_delay = 3;
        w_toggle = 1;
        gap_mode = 1;
        prod_en  = 1;
        start_frame(20, scyc);
        wait_done(600);
        total++;
        if (n_aw != 2 || aw_len_q[0] !== 8'd15 || aw_len_q[1] !== 8'd3) begin
            bad++; $display("FAIL bp_aw: got n=%0d want 2 bursts awlen 15,3", n_aw);
        end
        total++;
        if (n_aw_wait != 6) begin
            bad++; $display("FAIL bp_aw_wait: got %0d want 6", n_aw_wait);
        end
        total++;
        if (n_w != 20) begin
            bad++; $display("FAIL bp_beats: got %0d want 20", n_w);
        end
        for (int i = 0; i < n_w; i++) begin
            total++;
            if (wdata_q[i] !== 32'(i)) begin
                bad++; $display("FAIL bp_data[%0d]: got %0d want %0d", i, wdata_q[i], i);
            end
        end
        total++;
        if (n_wlast != 2 || wlast_idx[0] != 15 || wlast_idx[1] != 19) begin
            bad++; $display("FAIL bp_wlast: got n=%0d want 2 at 15,19", n_wlast);
        end
        total++;
        if (n_done != 1) begin
            bad++; $display("FAIL bp_done: got %0d want 1", n_done);
        end
    endtask

    task automatic test_slverr();
        int scyc;
        reset_all();
        bresp_tab[1] = 2'b10;
        prod_en = 1;
        start_frame(40, scyc);
        wait_done(400);
        total++;
        if (err_after.size() != 3 || err_after[0] !== 1'b0 || err_after[1] !== 1'b1 ||
            err_after[2] !== 1'b1) begin
            bad++; $display("FAIL err_timing: got n=%0d want err 0,1,1 after each B", err_after.size());
        end
        total++;
        if (n_aw != 3 || n_w != 40 || n_done != 1) begin
            bad++; $display("FAIL err_continue: got aw=%0d beats=%0d done=%0d want 3 40 1", n_aw, n_w, n_done);
        end
        total++;
        if (err_o !== 1'b1) begin
            bad++; $display("FAIL err_sticky: got %b want 1", err_o);
        end
        clear_mon();
        start_frame(1, scyc);
        wait_done(100);
        total++;
        if (err_o !== 1'b0 || n_done != 1) begin
            bad++; $display("FAIL err_clear: got err=%b done=%0d want 0 1", err_o, n_done);
        end
    endtask

    task automatic test_reset_mid();
        int scyc;
        reset_all();
        prod_en = 1;
        start_frame(10, scyc);
        for (int i = 0; i < 100; i++) begin
            if (n_w >= 2) break;
            @(posedge clk);
        end
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (axi_mosi_o !== '0 || {s_ready_o, busy_o, done_o, err_o} !== 4'b0000) begin
            bad++; $display("FAIL mid_reset: got mosi=%h ctrl=%b want 0 0000",
                            axi_mosi_o, {s_ready_o, busy_o, done_o, err_o});
        end
        reset_all();
        prod_en = 1;
        start_frame(4, scyc);
        wait_done(100);
        total++;
        if (n_aw != 1 || aw_len_q[0] !== 8'd3) begin
            bad++; $display("FAIL mid_aw: got n=%0d want 1 burst awlen 3", n_aw);
        end
        total++;
        if (n_w != 4 || n_wlast != 1 || wlast_idx[0] != 3 || n_done != 1) begin
            bad++; $display("FAIL mid_burst: got beats=%0d wlast=%0d done=%0d want 4 1 1", n_w, n_wlast, n_done);
        end
        for (int i = 0; i < n_w; i++) begin
            total++;
            if (wdata_q[i] !== 32'(i)) begin
                bad++; $display("FAIL mid_data[%0d]: got %0d want %0d", i, wdata_q[i], i);
            end
        end
    endtask

    initial begin
        rst        = 1'b0;
        start_i    = 1'b0;
        len_i      = '0;
        s_data_i   = '0;
        s_valid_i  = 1'b0;
        axi_miso_i = '0;
        prod_en    = 0;
        prod_word  = 0;
        gap_ph     = 0;
        aw_delay   = 0;
        w_toggle   = 0;
        gap_mode   = 0;
        b_idx      = 0;
        b_pending  = 0;
        foreach (bresp_tab[i]) bresp_tab[i] = 2'b00;
        clear_mon();
        reset_all();
        test_reset();
        test_single();
        test_multi();
        test_exact();
        test_zero();
        test_backpressure();
        test_slverr();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/eth_outfifo_axi_writer.md
# eth_outfifo_axi_writer

AXI4 write initiator that takes a frame as a 32-bit word stream and pushes it into the Ethernet OUTFIFO AXI4 slave window using INCR bursts. It sits between a packet producer (CPU-less datapath, DMA, or bench stimulus) and `ethernet_wrapper`'s `eth_outfifo_mosi_i` / `eth_outfifo_miso_o` port pair. It is the master-side counterpart of the OUTFIFO slave. Each frame is one `start_i` command. The block splits the frame into bursts of at most `MAX_BURST` beats and reports completion and any write-response error.

## Interface
Parameters:
- `BASE_ADDR`, default `32'h0`: OUTFIFO window address. Every burst's `awaddr` equals this value, because the window is a FIFO and does not advance.
- `MAX_BURST`, default `16`: maximum beats per burst. Legal range is 1..256.
- `LEN_W`, default `16`: width of the frame length in words.

Ports:
- `clk`  in  1: sole clock.
- `rst`  in  1: asynchronous reset, active-low.
- `start_i`  in  1: frame command. Sampled only in IDLE.
- `len_i`  in  LEN_W: frame length in 32-bit words. Sampled with `start_i`.
- `s_data_i`  in  32: stream data word.
- `s_valid_i`  in  1: stream word valid. The producer holds it and `s_data_i` stable until `s_ready_o`.
- `s_ready_o`  out  1: stream word accepted.
- `busy_o`  out  1: a frame is in progress.
- `done_o`  out  1: single-cycle pulse when the frame completes.
- `err_o`  out  1: sticky. Set by any `bresp` other than OKAY. Cleared on the next accepted `start_i`.
- `axi_mosi_o`  out  s_axi_mosi_t: AXI4 master request, connected to `eth_outfifo_mosi_i`.
- `axi_miso_i`  in  s_axi_miso_t: AXI4 slave response, connected from `eth_outfifo_miso_o`.

## Operation
- **Registers:** `rem` holds the words remaining in the frame. `beats` holds the beats in the current burst. `cnt` is the beat index.
- **State machine:** IDLE → AW → W → B → (AW | DONE) → IDLE.
- **IDLE:**
  - `start_i` with `len_i`≠0: load `rem`=`len_i`, clear `err_o`, go to AW.
  - `start_i` with `len_i`=0: go to DONE with no AXI traffic.
- **AW:**
  - `beats` = min(`rem`, `MAX_BURST`), computed in `LEN_W+1` bits.
  - Drive `awvalid`=1 with:
    - `awaddr`=`BASE_ADDR`, `awlen`=`beats`-1, `awsize`=3'd2, `awburst`=INCR (2'b01);
    - `awid`=0, `awlock`/`awcache`/`awprot`/`awqos`/`awregion`/`awuser`=0.
  - AW fields are registered and held stable until `awready`. On the handshake go to W with `cnt`=0.
- **W:**
  - `wvalid`=`s_valid_i`, `wdata`=`s_data_i`, `s_ready_o`=`wready`.
  - `wstrb`=4'hF, `wuser`=0, `wlast`=(`cnt`==`beats`-1).
  - On each beat: `cnt`++ and `rem`--.
  - After the `wlast` beat go to B.
  - No W beat is issued before its AW handshake.
- **B:**
  - `bready`=1.
  - On `bvalid`: if `bresp`≠2'b00, set `err_o`.
  - Then go to AW if `rem`≠0, else DONE.
  - An error does not abort the frame; all remaining bursts are still issued and the stream is fully consumed.
- **DONE:** `done_o`=1 for one cycle, then go to IDLE.
- **Read channels:** tied off, with `arvalid`=0, `rready`=0 and all AR fields 0.

## Timing
- **Reset values:**
  - `s_ready_o`=0, `busy_o`=0, `done_o`=0, `err_o`=0.
  - All `axi_mosi_o` fields are 0, including `awvalid`, `wvalid` and `bready`.
  - State is IDLE and all counters are 0.
- **Reset mid-operation:** the in-flight transaction is abandoned immediately. Outputs go to their reset values asynchronously. The next `start_i` after release behaves as a fresh frame.
- **Latency:**
  - `start_i` in cycle N gives `awvalid` in cycle N+1.
  - `s_ready_o` and `wvalid` are combinational from `wready` and `s_valid_i`, so there are 0 cycles from stream to W.
  - `bvalid` handshake in cycle M gives the next `awvalid`, or `done_o`, in cycle M+1.
  - Best-case throughput is one W beat per cycle within a burst. The per-burst overhead is AW + B, at least 2 cycles.
- **`busy_o`:** 1 in AW, W and B. 0 in IDLE and DONE.
- **Ignored starts:** `start_i` is ignored while `busy_o`=1 or `done_o`=1.
- **Length boundaries:**
  - `len_i`=2^LEN_W−1 must be handled without overflow.
  - When `rem` is an exact multiple of `MAX_BURST`, the last burst is full and no zero-length burst is issued.
- **Simultaneous events:** `awready` asserted in the same cycle as `awvalid` rises counts as a handshake.

## Test plan
- `len_i`=5, `MAX_BURST`=16, slave always ready → one AW with `awlen`=4 and `awaddr`=`BASE_ADDR`; 5 W beats with `wlast` on beat 5; `bresp` OKAY; `done_o` 1 cycle after `bvalid`; `err_o`=0.
- `len_i`=40 → three bursts with `awlen`=15, 15, 7; 40 words delivered in order (data 0..39); exactly one `done_o`.
- `len_i`=32 → two bursts with `awlen`=15, 15; no third AW.
- `len_i`=0 → `done_o` in cycle N+2; `awvalid` never asserted; `busy_o` stays 0.
- Backpressure: `awready` delayed 3 cycles, `wready` toggling, `s_valid_i` gapped → AW fields stable while waiting; no beat lost or duplicated; `wlast` exact.
- `bresp`=SLVERR on burst 2 of `len_i`=40 → `err_o`=1 from the cycle after that B; burst 3 still issued; `done_o` pulses; next `start_i` clears `err_o`.
- `rst` asserted low during W beat 3 → all outputs 0 immediately; after release, `start_i` with `len_i`=4 → one clean burst with `awlen`=3.
